// File: rtl/fifo_push_arb.sv
// Round-robin arbiter sharing the push side of one fifo_ctrl between N requesters,
// with bursts of up to MAX_BURST pushes per grant. Define FIFO_PUSH_ARB_FIXED_PRI_EN for fixed priority.
module fifo_push_arb #(
  parameter int N         = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4,
  localparam int IDW      = $clog2(N),
  localparam int BCW      = $clog2(MAX_BURST + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req_valid,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    req_ready,
  input  logic            fifo_full,
  output logic            fifo_push,
  output logic [DW-1:0]   fifo_wr_data,
  output logic [IDW-1:0]  grant_id,
  output logic            busy
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t         r_state, w_state_nxt;
  logic [IDW-1:0] r_owner, w_owner_nxt, w_sel;
  logic [BCW-1:0] r_burst_cnt, w_burst_cnt_nxt;
  logic           r_busy;
  logic           w_grant_ok;
`ifndef FIFO_PUSH_ARB_FIXED_PRI_EN
  logic [IDW-1:0] r_rr_ptr, w_rr_ptr_nxt;
`endif

  // Explicit wrap so non-power-of-2 N rotates correctly.
  function automatic logic [IDW-1:0] f_next_idx(input logic [IDW-1:0] v);
    return (v == IDW'(N - 1)) ? '0 : v + IDW'(1);
  endfunction

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_sel = r_owner;
    if (r_state == S_IDLE) begin
      w_sel = '0;
      // Scan from the far end so the nearest valid requester is assigned last and wins.
`ifdef FIFO_PUSH_ARB_FIXED_PRI_EN
      for (int i = N - 1; i >= 0; i--)
        if (req_valid[i]) w_sel = IDW'(i);
`else
      for (int k = N - 1; k >= 0; k--)
        if (req_valid[(int'(r_rr_ptr) + k) % N]) w_sel = IDW'((int'(r_rr_ptr) + k) % N);
`endif
    end
  end

  always_comb begin
    w_grant_ok = (r_state == S_IDLE) ? (|req_valid) : req_valid[r_owner];
    req_ready  = '0;
    if (!reset && w_grant_ok && !fifo_full) req_ready[w_sel] = 1'b1;
  end

  // Ready is only offered when the FIFO has room, so every push is accepted downstream.
  assign fifo_push    = |(req_valid & req_ready);
  assign fifo_wr_data = req_data[int'(w_sel) * DW +: DW];
  assign grant_id     = r_owner;
  assign busy         = r_busy;

  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_burst_cnt_nxt = r_burst_cnt;
`ifndef FIFO_PUSH_ARB_FIXED_PRI_EN
    w_rr_ptr_nxt    = r_rr_ptr;
`endif
    case (r_state)
      S_IDLE: begin
        if (fifo_push) begin
          w_owner_nxt     = w_sel;
          w_burst_cnt_nxt = BCW'(1);
          if (MAX_BURST == 1) begin
`ifndef FIFO_PUSH_ARB_FIXED_PRI_EN
            w_rr_ptr_nxt = f_next_idx(w_sel);
`endif
          end else begin
            w_state_nxt = S_BURST;
          end
        end
      end
      S_BURST: begin
        if (req_valid[r_owner] && !fifo_full) begin
          w_burst_cnt_nxt = r_burst_cnt + BCW'(1);
          if (r_burst_cnt + BCW'(1) == BCW'(MAX_BURST)) begin
`ifndef FIFO_PUSH_ARB_FIXED_PRI_EN
            w_rr_ptr_nxt = f_next_idx(r_owner);
`endif
            w_burst_cnt_nxt = '0;
            w_state_nxt     = S_IDLE;
          end
        end else if (!req_valid[r_owner]) begin
          // Owner dropped valid: give up the grant, costing one bubble cycle.
`ifndef FIFO_PUSH_ARB_FIXED_PRI_EN
          w_rr_ptr_nxt = f_next_idx(r_owner);
`endif
          w_burst_cnt_nxt = '0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_owner     <= '0;
      r_burst_cnt <= '0;
      r_busy      <= 1'b0;
`ifndef FIFO_PUSH_ARB_FIXED_PRI_EN
      r_rr_ptr    <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_busy      <= (w_state_nxt == S_BURST);
`ifndef FIFO_PUSH_ARB_FIXED_PRI_EN
      r_rr_ptr    <= w_rr_ptr_nxt;
`endif
    end
  end

endmodule
